map_scanner: RTL

Initiator side of the map tile lookup interface. On a start pulse, walks the 13×13 tile map in row-major order and drives the tile-lookup port (enable, x, y). Samples the combinational block type that comes back and presents each tile to the renderer/collision logic over a valid/ready stream, optionally dropping AIR tiles. Sits between the map tile lookup block and the tile-drawing pipeline; one full scan per frame.

---
 rtl/map_pkg.sv | 27 ++
 rtl/map_xy_counter.sv | 41 ++++
 rtl/map_scanner.sv | 110 +++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared definitions for the tile map: block encodings, map dimensions and
// the scanner FSM state type.
package map_pkg;

  localparam int unsigned MAP_W = 13;
  localparam int unsigned MAP_H = 13;

  typedef enum logic [2:0] {
    BRICK = 3'b000,
    WALL  = 3'b001,
    TREE  = 3'b010,
    WATER = 3'b011,
    AIR   = 3'b111
  } block_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DONE
  } scan_state_t;

  function automatic logic is_air(input logic [2:0] t);
    return t == AIR;
  endfunction

endpackage

// File: rtl/map_xy_counter.sv
// Row-major x/y tile position counter with synchronous clear, advance and a
// last-tile flag; y saturates at the last row instead of wrapping.
module map_xy_counter #(
  parameter int unsigned MAP_W = 13,
  parameter int unsigned MAP_H = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       last
);

  localparam logic [3:0] X_LAST = 4'(MAP_W - 1);
  localparam logic [3:0] Y_LAST = 4'(MAP_H - 1);

  logic x_at_end;

  assign x_at_end = (x == X_LAST);
  assign last     = x_at_end && (y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance && !last) begin
      if (x_at_end) begin
        x <= '0;
        y <= y + 4'd1;
      end else begin
        x <= x + 4'd1;
      end
    end
  end

endmodule

// File: rtl/map_scanner.sv
// Walks the tile map in row-major order through the lookup port and streams
// each fetched tile (optionally dropping AIR) over a valid/ready interface.
module map_scanner #(
  parameter int unsigned MAP_W    = map_pkg::MAP_W,
  parameter int unsigned MAP_H    = map_pkg::MAP_H,
  parameter bit          SKIP_AIR = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       map_enable_o,
  output logic [3:0] map_x_o,
  output logic [3:0] map_y_o,
  input  logic [2:0] block_type_i,
  output logic       tile_valid_o,
  input  logic       tile_ready_i,
  output logic [3:0] tile_x_o,
  output logic [3:0] tile_y_o,
  output logic [2:0] tile_type_o,
  output logic [7:0] tile_count_o
);

  import map_pkg::*;

  scan_state_t state;

  logic       cnt_clear;
  logic       cnt_advance;
  logic       cnt_last;
  logic [3:0] cnt_x;
  logic [3:0] cnt_y;
  logic       skip_tile;
  logic       handshake;

  map_xy_counter #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_counter (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

  assign skip_tile = SKIP_AIR && is_air(block_type_i);
  assign handshake = (state == S_HOLD) && tile_ready_i;

  // The counter moves only after a tile is consumed or dropped, so the lookup
  // address stays on the held tile throughout backpressure.
  always_comb begin
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    case (state)
      S_IDLE:  cnt_clear   = start_i;
      S_FETCH: cnt_advance = skip_tile && !cnt_last;
      S_HOLD:  cnt_advance = tile_ready_i && !cnt_last;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      tile_x_o     <= '0;
      tile_y_o     <= '0;
      tile_type_o  <= '0;
      tile_count_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            tile_count_o <= '0;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (skip_tile) begin
            if (cnt_last) state <= S_DONE;
          end else begin
            tile_x_o    <= cnt_x;
            tile_y_o    <= cnt_y;
            tile_type_o <= block_type_i;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (handshake) begin
            tile_count_o <= tile_count_o + 8'd1;
            state        <= cnt_last ? S_DONE : S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);
  assign map_enable_o = (state == S_FETCH);
  assign tile_valid_o = (state == S_HOLD);
  assign map_x_o      = cnt_x;
  assign map_y_o      = cnt_y;

endmodule
